// File: rtl/cbus_arbiter_pkg.sv
// Shared cache-bus types used by the arbiter and the cache-bus-to-AXI bridge.
package cbus_arbiter_pkg;

    localparam int unsigned CBUS_MAX_INPUTS = 8;
    localparam int unsigned CBUS_ADDR_W     = 32;
    localparam int unsigned CBUS_DATA_W     = 32;
    localparam int unsigned CBUS_STRB_W     = CBUS_DATA_W / 8;
    localparam int unsigned CBUS_MLEN_W     = 4;

    // Burst length is encoded as beats minus one.
    typedef logic [CBUS_MLEN_W-1:0] mlen_t;

    typedef struct packed {
        logic                   valid;
        logic                   is_write;
        logic [CBUS_ADDR_W-1:0] addr;
        logic [CBUS_STRB_W-1:0] strobe;
        logic [CBUS_DATA_W-1:0] data;
        mlen_t                  len;
    } cbus_req_t;

    typedef struct packed {
        logic                   ready;
        logic                   last;
        logic [CBUS_DATA_W-1:0] data;
    } cbus_resp_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/cbus_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first valid at or after ptr, modulo NUM_INPUTS.
module cbus_arbiter_rr_pick #(
    parameter int unsigned NUM_INPUTS = 2,
    parameter int unsigned IDX_W      = $clog2(NUM_INPUTS)
) (
    input  logic [NUM_INPUTS-1:0] valid,
    input  logic [IDX_W-1:0]      ptr,
    output logic [IDX_W-1:0]      idx,
    output logic                  any
);

    logic [IDX_W-1:0] cand;

    // Scan offsets from farthest to nearest so the nearest valid requester wins.
    always_comb begin
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int k = int'(NUM_INPUTS) - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(ptr) + k) % int'(NUM_INPUTS));
            if (valid[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cbus_arbiter.sv
// Round-robin cache-bus arbiter: holds one grant per burst and routes request/response
// between the granted requester and the single bridge port.
module cbus_arbiter
    import cbus_arbiter_pkg::*;
#(
    parameter int unsigned NUM_INPUTS = 2,
    parameter int unsigned IDX_W      = $clog2(NUM_INPUTS)
) (
    input  logic             clk,
    input  logic             reset,
    input  cbus_req_t        ireqs  [NUM_INPUTS],
    output cbus_resp_t       iresps [NUM_INPUTS],
    output cbus_req_t        oreq,
    input  cbus_resp_t       oresp,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx,
    output logic             proto_err
);

    arb_state_t            state_q, state_d;
    logic [IDX_W-1:0]      grant_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    mlen_t                 beat_q, beat_d;
    logic                  err_d;
    logic [NUM_INPUTS-1:0] req_valid;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_any;
    cbus_req_t             cur_req;

    always_comb begin
        req_valid = '0;
        for (int i = 0; i < int'(NUM_INPUTS); i++) begin
            req_valid[i] = ireqs[i].valid;
        end
    end

    cbus_arbiter_rr_pick #(
        .NUM_INPUTS (NUM_INPUTS),
        .IDX_W      (IDX_W)
    ) u_rr_pick (
        .valid (req_valid),
        .ptr   (rr_ptr_q),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign cur_req     = ireqs[grant_idx];
    assign grant_valid = (state_q == ARB_BUSY);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ARB_IDLE;
            grant_idx <= '0;
            rr_ptr_q  <= '0;
            beat_q    <= '0;
            proto_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_idx <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            beat_q    <= beat_d;
            proto_err <= err_d;
        end
    end

    // IDLE drives nothing downstream, so the grant always costs one registered cycle.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_idx;
        rr_ptr_d = rr_ptr_q;
        beat_d   = beat_q;
        err_d    = proto_err;
        oreq     = '0;
        for (int i = 0; i < int'(NUM_INPUTS); i++) begin
            iresps[i] = '0;
        end

        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    beat_d  = '0;
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                oreq              = cur_req;
                oreq.valid        = 1'b1;
                iresps[grant_idx] = oresp;
                if (!cur_req.valid) begin
                    err_d = 1'b1;
                end
                if (oresp.ready) begin
                    beat_d = beat_q + mlen_t'(1);
                end
                if (oresp.ready && oresp.last) begin
                    if (beat_q != cur_req.len) begin
                        err_d = 1'b1;
                    end
                    rr_ptr_d = (grant_idx == IDX_W'(NUM_INPUTS - 1)) ? '0
                                                                      : grant_idx + IDX_W'(1);
                    grant_d  = '0;
                    state_d  = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Self-checking bench for cbus_arbiter: directed scenarios followed by randomized traffic
// checked against a round-robin transaction-level model.
module tb_cbus_arbiter;
    import cbus_arbiter_pkg::*;

    localparam int unsigned N = 2;

    logic                   clk = 1'b0;
    logic                   reset;
    cbus_req_t              ireqs  [N];
    cbus_resp_t             iresps [N];
    cbus_req_t              oreq;
    cbus_resp_t             oresp;
    logic                   grant_valid;
    logic [$clog2(N)-1:0]   grant_idx;
    logic                   proto_err;

    int checks = 0;
    int errors = 0;
    int m_ptr  = 0;

    always #5 clk = ~clk;

    cbus_arbiter #(.NUM_INPUTS(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .ireqs       (ireqs),
        .iresps      (iresps),
        .oreq        (oreq),
        .oresp       (oresp),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .proto_err   (proto_err)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    function automatic cbus_req_t mk_req(input logic wr, input logic [31:0] addr,
                                         input mlen_t len, input logic [31:0] data,
                                         input logic [3:0] strobe);
        cbus_req_t r;
        r.valid    = 1'b1;
        r.is_write = wr;
        r.addr     = addr;
        r.strobe   = strobe;
        r.data     = data;
        r.len      = len;
        return r;
    endfunction

    // Model: lowest valid index at or above the pointer, else lowest valid index overall.
    function automatic int winner(input logic [N-1:0] v, input int ptr);
        for (int i = ptr; i < int'(N); i++) if (v[i]) return i;
        for (int i = 0; i < ptr; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [N-1:0] valid_mask();
        logic [N-1:0] v;
        for (int i = 0; i < int'(N); i++) v[i] = ireqs[i].valid;
        return v;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < int'(N); i++) ireqs[i] = '0;
        oresp = '0;
        cyc();
        cyc();
        reset = 1'b0;
        m_ptr = 0;
    endtask

    task automatic idle_check();
        settle();
        chk("idle_oreq", 128'(oreq), 128'(0));
        for (int i = 0; i < int'(N); i++) chk("idle_iresp", 128'(iresps[i]), 128'(0));
        chk("idle_gvalid", 128'(grant_valid), 128'(0));
        chk("idle_gidx", 128'(grant_idx), 128'(0));
    endtask

    // Act as the bridge for an expected grant to w: nb ready beats, last on the final one.
    task automatic serve(input int w, input int nb, input int drop_at, input bit gaps);
        int        b     = 0;
        int        stall = 0;
        cbus_req_t want_req;
        while (b < nb) begin
            if (b == drop_at) ireqs[w].valid = 1'b0;
            oresp.ready = !gaps || (stall >= 2) || ($urandom_range(0, 2) != 0);
            oresp.last  = oresp.ready && (b == nb - 1);
            oresp.data  = $urandom;
            settle();
            want_req       = ireqs[w];
            want_req.valid = 1'b1;
            chk("busy_oreq", 128'(oreq), 128'(want_req));
            chk("busy_gidx", 128'(grant_idx), 128'(w));
            chk("busy_gvalid", 128'(grant_valid), 128'(1));
            for (int i = 0; i < int'(N); i++) begin
                if (i == w) chk("iresp_grant", 128'(iresps[i]), 128'(oresp));
                else        chk("iresp_other", 128'(iresps[i]), 128'(0));
            end
            if (oresp.ready) begin
                b++;
                stall = 0;
            end else begin
                stall++;
            end
            cyc();
        end
        oresp = '0;
    endtask

    initial begin
        int w;
        logic [N-1:0] v;

        // Reset values while reset is held.
        reset = 1'b1;
        for (int i = 0; i < int'(N); i++) ireqs[i] = '0;
        oresp = '0;
        cyc();
        idle_check();
        chk("rst_proto_err", 128'(proto_err), 128'(0));
        cyc();
        reset = 1'b0;

        // Single requester, read of 4 beats.
        ireqs[0] = mk_req(1'b0, 32'h1fc00000, 4'd3, 32'h0, 4'h0);
        idle_check();
        cyc();
        serve(0, 4, -1, 1'b0);
        ireqs[0].valid = 1'b0;
        m_ptr = 1;
        idle_check();
        chk("single_err", 128'(proto_err), 128'(0));

        // Simultaneous requests from pointer 0.
        do_reset();
        ireqs[0] = mk_req(1'b0, 32'h00001000, 4'd1, 32'h0, 4'h0);
        ireqs[1] = mk_req(1'b0, 32'h00002000, 4'd2, 32'h0, 4'h0);
        w = winner(valid_mask(), m_ptr);
        idle_check();
        cyc();
        serve(w, 2, -1, 1'b0);
        ireqs[w].valid = 1'b0;
        m_ptr = (w + 1) % int'(N);
        idle_check();
        cyc();
        w = winner(valid_mask(), m_ptr);
        serve(w, 3, -1, 1'b1);
        ireqs[w].valid = 1'b0;
        m_ptr = (w + 1) % int'(N);

        // Fairness: both keep requesting; grants alternate starting at 0.
        ireqs[0] = mk_req(1'b0, $urandom, 4'($urandom_range(0, 3)), $urandom, 4'h0);
        ireqs[1] = mk_req(1'b0, $urandom, 4'($urandom_range(0, 3)), $urandom, 4'h0);
        for (int k = 0; k < 8; k++) begin
            idle_check();
            cyc();
            serve(k % 2, int'(ireqs[k % 2].len) + 1, -1, 1'b1);
            ireqs[k % 2] = mk_req(1'b0, $urandom, 4'($urandom_range(0, 3)), $urandom, 4'h0);
            m_ptr = (k % 2 + 1) % int'(N);
        end
        ireqs[0] = '0;
        ireqs[1] = '0;
        idle_check();
        cyc();

        // Single-beat write on requester 1.
        ireqs[1] = mk_req(1'b1, 32'h00003000, 4'd0, 32'hdeadbeef, 4'b1111);
        idle_check();
        cyc();
        settle();
        chk("write_data", 128'(oreq.data), 128'(32'hdeadbeef));
        chk("write_strobe", 128'(oreq.strobe), 128'(4'b1111));
        serve(1, 1, -1, 1'b0);
        ireqs[1].valid = 1'b0;
        m_ptr = 0;
        settle();
        chk("write_err", 128'(proto_err), 128'(0));

        // Early last: 2 beats against len=3.
        ireqs[0] = mk_req(1'b0, 32'h00004000, 4'd3, 32'h0, 4'h0);
        idle_check();
        cyc();
        serve(0, 2, -1, 1'b0);
        ireqs[0].valid = 1'b0;
        settle();
        chk("short_err", 128'(proto_err), 128'(1));
        cyc();
        cyc();
        cyc();
        settle();
        chk("short_err_held", 128'(proto_err), 128'(1));
        do_reset();
        settle();
        chk("short_err_clr", 128'(proto_err), 128'(0));

        // Requester drops valid mid-burst; forwarding continues.
        ireqs[0] = mk_req(1'b0, 32'h00005000, 4'd3, 32'h0, 4'h0);
        idle_check();
        cyc();
        serve(0, 4, 1, 1'b0);
        m_ptr = 1;
        settle();
        chk("drop_err", 128'(proto_err), 128'(1));
        do_reset();

        // Reset during a len=7 burst after its first beat.
        ireqs[0] = mk_req(1'b0, 32'h00006000, 4'd7, 32'h0, 4'h0);
        idle_check();
        cyc();
        oresp.ready = 1'b1;
        oresp.last  = 1'b0;
        oresp.data  = 32'h0badf00d;
        settle();
        chk("rb_beat1", 128'(iresps[0]), 128'(oresp));
        cyc();
        reset    = 1'b1;
        ireqs[0] = '0;
        oresp    = '0;
        cyc();
        reset = 1'b0;
        m_ptr = 0;
        idle_check();
        chk("rb_err", 128'(proto_err), 128'(0));
        ireqs[0] = mk_req(1'b0, 32'h00007000, 4'd0, 32'h0, 4'h0);
        idle_check();
        cyc();
        serve(0, 1, -1, 1'b0);
        ireqs[0].valid = 1'b0;
        m_ptr = 1;

        // Randomized traffic against the round-robin model.
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < int'(N); i++) begin
                if (!ireqs[i].valid && ($urandom_range(0, 1) != 0))
                    ireqs[i] = mk_req(1'($urandom_range(0, 1)), $urandom,
                                      4'($urandom_range(0, 3)), $urandom, 4'($urandom));
            end
            v = valid_mask();
            if (v == '0) begin
                w = int'($urandom_range(0, N - 1));
                ireqs[w] = mk_req(1'b0, $urandom, 4'($urandom_range(0, 3)), $urandom, 4'hf);
                v = valid_mask();
            end
            w = winner(v, m_ptr);
            idle_check();
            cyc();
            serve(w, int'(ireqs[w].len) + 1, -1, 1'b1);
            ireqs[w].valid = 1'b0;
            m_ptr = (w + 1) % int'(N);
        end
        settle();
        chk("rand_err", 128'(proto_err), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cbus_arbiter.md
# cbus_arbiter

Round-robin arbiter that shares one cache-bus port between NUM_INPUTS requesters (I-cache, D-cache, uncached path) and drives the single cache-bus-to-AXI bridge. It grants one requester at a time and holds the grant for the whole burst, until the bridge signals the final beat. It routes the selected request downstream and returns the response to the granted requester only.

## Interface
- NUM_INPUTS, default 2: number of requesters, 2..8.
- IDX_W, default $clog2(NUM_INPUTS): grant index width, derived.

- clk, input, 1: clock.
- reset, input, 1: reset. Synchronous, active-high; one clock, all state on posedge clk.
- ireqs, input, cbus_req_t[NUM_INPUTS]: requester requests.
- iresps, output, cbus_resp_t[NUM_INPUTS]: responses, one per requester.
- oreq, output, cbus_req_t: request to the bridge.
- oresp, input, cbus_resp_t: response from the bridge.
- grant_valid, output, 1: a transaction is in progress.
- grant_idx, output, IDX_W: index of the granted requester; 0 when idle.
- proto_err, output, 1: sticky protocol-violation flag.

## Operation
- States: IDLE and BUSY. Registers: state, grant_idx, rr_ptr (IDX_W), beat_cnt (mlen_t), proto_err.
- IDLE
  - oreq is all-zero and every iresps entry is all-zero.
  - Pick the first i with ireqs[i].valid, scanning from rr_ptr upward modulo NUM_INPUTS.
  - If any requester is valid: register grant_idx=i, clear beat_cnt, then go to BUSY.
- BUSY
  - oreq = ireqs[grant_idx] combinationally, with oreq.valid forced to 1.
  - iresps[grant_idx] = oresp; all other iresps entries are all-zero.
  - Each cycle with oresp.ready=1, beat_cnt increments (mlen_t arithmetic, wraps).
  - On oresp.ready && oresp.last: set rr_ptr = grant_idx+1 (wrapping to 0 past NUM_INPUTS-1), then go to IDLE.
- Protocol checks. proto_err is set and held until reset if, in BUSY, either:
  - ireqs[grant_idx].valid falls before the last beat, or
  - oresp.last arrives with beat_cnt != ireqs[grant_idx].len.
  - Forwarding continues unchanged after an error; proto_err is diagnostic only.
- Requesters must hold every request field stable from valid until they see iresps[i].last. The bridge samples the request on the first valid cycle only.

## Timing
- Reset values:
  - state=IDLE, grant_idx=0, rr_ptr=0, beat_cnt=0, proto_err=0.
  - oreq=0, all iresps=0, grant_valid=0.
- Grant latency: one cycle. A request valid in cycle t appears on oreq in cycle t+1 at the earliest.
- Response path (oresp to iresps) is purely combinational, zero latency.
- Release: the cycle after the last beat is IDLE, with oreq.valid=0. The next grant appears on oreq at the earliest two cycles after the last beat. This guarantees the bridge sees valid deassert between transactions.
- Simultaneous requests: the winner is the requester at or after rr_ptr. The loser keeps valid asserted and is granted next, so no requester starves beyond NUM_INPUTS-1 transactions.
- A single-beat transaction (len=0) has ready and last in the same cycle; this is legal.
- Reset asserted in BUSY: the next cycle is IDLE and the outstanding burst is abandoned. The bridge must be reset together with the arbiter.
- No combinational path from ireqs to oreq while IDLE.

## Structure
- The shared package supplies cbus_req_t, cbus_resp_t and mlen_t; the same types are used by the bridge.
- Add CBUS_MAX_INPUTS=8 to the package.
- One sub-module, rr_pick: combinational round-robin priority encoder taking valid[NUM_INPUTS] and ptr, returning idx and any.
- Reusable by a future AXI write-back buffer arbiter.

## Test plan
- Single requester: req0 read, addr=0x1fc00000, len=3.
  - oreq.valid appears one cycle later; iresps[0] receives 4 ready beats, last on the 4th.
  - Then one IDLE cycle with oreq.valid=0.
- Simultaneous requests: req0 and req1 valid in the same cycle, rr_ptr=0.
  - req0 is served first (len=1).
  - req1 is granted 2 cycles after req0's last beat.
  - rr_ptr ends at 0 after req1 completes.
- Fairness: req0 re-requests continuously and req1 is always valid.
  - Grants alternate 0,1,0,1 over 8 transactions.
  - iresps[1] stays 0 while req0 is served.
- Write: req1 write, len=0, strobe=4'b1111, data=0xdeadbeef.
  - oreq.data equals 0xdeadbeef while granted.
  - Single beat with ready and last together; proto_err stays 0.
- Violations:
  - Bridge asserts last after 2 beats with len=3: proto_err=1, held.
  - Separately, req0 drops valid mid-burst: proto_err=1.
- Reset in BUSY after beat 1 of len=7: next cycle all outputs are 0 and state is IDLE; a new req0 is then granted normally.
